// File: rtl/mig_app_master.sv
// Single-outstanding request initiator for the MIG app_* interface: waits for
// calibration, issues one BL8 read or write, returns data or a timeout flag.
module mig_app_master #(
   parameter int ADDR_W     = 28,
   parameter int DATA_W     = 512,
   parameter int MASK_W     = 64,
   parameter int RD_TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [MASK_W-1:0] req_wmask,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [DATA_W-1:0] app_wdf_data,
   output logic [MASK_W-1:0] app_wdf_mask,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   input  logic              app_wdf_rdy,
   input  logic [DATA_W-1:0] app_rd_data,
   input  logic              app_rd_data_valid,
   input  logic              init_calib_complete,
   output logic              unexp_rd
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_WAIT_CAL,
      S_IDLE,
      S_WR,
      S_RD_CMD,
      S_RD_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [MASK_W-1:0] wmask_q, wmask_d;
   logic              cmd_done_q, cmd_done_d;
   logic              wdf_done_q, wdf_done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              unexp_q, unexp_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_WAIT_CAL;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         cmd_done_q  <= 1'b0;
         wdf_done_q  <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
         unexp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         cmd_done_q  <= cmd_done_d;
         wdf_done_q  <= wdf_done_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
         unexp_q     <= unexp_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      cmd_done_d   = cmd_done_q;
      wdf_done_d   = wdf_done_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = 1'b0;
      rdata_d      = rdata_q;
      unexp_d      = unexp_q;
      req_ready    = 1'b0;
      app_en       = 1'b0;
      app_cmd      = 3'd0;
      app_wdf_wren = 1'b0;

      // Any read beat outside RD_WAIT (including a late beat after timeout) is stray.
      if (app_rd_data_valid && state_q != S_RD_WAIT) unexp_d = 1'b1;

      case (state_q)
         S_WAIT_CAL: begin
            if (init_calib_complete) state_d = S_IDLE;
         end
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               wmask_d    = req_wmask;
               cmd_done_d = 1'b0;
               wdf_done_d = 1'b0;
               state_d    = req_write ? S_WR : S_RD_CMD;
            end
         end
         S_WR: begin
            // Command and data strobes retire independently; respond once both have.
            app_en       = ~cmd_done_q;
            app_wdf_wren = ~wdf_done_q;
            cmd_done_d   = cmd_done_q | app_rdy;
            wdf_done_d   = wdf_done_q | app_wdf_rdy;
            if (cmd_done_d && wdf_done_d) begin
               rsp_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_RD_CMD: begin
            app_en  = 1'b1;
            app_cmd = 3'd1;
            if (app_rdy) begin
               cnt_d   = '0;
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (app_rd_data_valid) begin
               rdata_d     = app_rd_data;
               rsp_valid_d = 1'b1;
               state_d     = S_IDLE;
            end else if (cnt_q == CNT_W'(RD_TIMEOUT)) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_WAIT_CAL;
      endcase
   end

   assign app_addr     = addr_q;
   assign app_wdf_data = wdata_q;
   assign app_wdf_mask = wmask_q;
   assign app_wdf_end  = app_wdf_wren;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_err      = rsp_err_q;
   assign rsp_rdata    = rdata_q;
   assign unexp_rd     = unexp_q;

endmodule

// File: tb/tb_mig_app_master.sv
// Directed bench for mig_app_master: a byte-masked memory stands in for the MIG,
// read beats are driven by the read task with a chosen latency or withheld.
module tb_mig_app_master;
   localparam int ADDR_W     = 28;
   localparam int DATA_W     = 512;
   localparam int MASK_W     = 64;
   localparam int RD_TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rstn;
   logic              req_valid, req_ready, req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [MASK_W-1:0] req_wmask;
   logic              rsp_valid, rsp_err;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] app_addr;
   logic [2:0]        app_cmd;
   logic              app_en, app_rdy;
   logic [DATA_W-1:0] app_wdf_data;
   logic [MASK_W-1:0] app_wdf_mask;
   logic              app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [DATA_W-1:0] app_rd_data;
   logic              app_rd_data_valid, init_calib_complete, unexp_rd;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

   always #5 clk = ~clk;

   mig_app_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RD_TIMEOUT(RD_TIMEOUT)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
      .init_calib_complete(init_calib_complete), .unexp_rd(unexp_rd)
   );

   // Memory model: a masked byte is left untouched.
   always @(posedge clk) begin : mem_model
      logic [DATA_W-1:0] w;
      if (app_wdf_wren && app_wdf_rdy) begin
         w = mem.exists(app_addr) ? mem[app_addr] : '0;
         for (int b = 0; b < MASK_W; b++)
            if (!app_wdf_mask[b]) w[b*8 +: 8] = app_wdf_data[b*8 +: 8];
         mem[app_addr] = w;
      end
   end

   // Called at a negedge; returns at a negedge.
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [MASK_W-1:0] m, input int en_delay,
                           output int acc_wait, output int en_n, output int wren_n,
                           output int rsp_n, output int rsp_k, output int bad);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
      app_rdy = 1'b0; app_wdf_rdy = 1'b1;
      acc_wait = 0;
      while (!req_ready && acc_wait < 20) begin
         @(negedge clk);
         acc_wait++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      en_n = 0; wren_n = 0; rsp_n = 0; rsp_k = -1; bad = 0;
      for (int k = 0; k < en_delay + 6; k++) begin
         if (app_en) begin
            en_n++;
            if (app_cmd !== 3'd0 || app_addr !== a) bad++;
         end
         if (app_wdf_wren) begin
            wren_n++;
            if (app_wdf_data !== d || app_wdf_mask !== m) bad++;
         end
         if (app_wdf_end !== app_wdf_wren) bad++;
         if (rsp_valid) begin
            rsp_n++;
            if (rsp_k < 0) rsp_k = k;
         end
         app_rdy = (k >= en_delay);
         @(negedge clk);
      end
      app_rdy = 1'b0;
      $display("WRITE addr=%h stall=%0d en=%0d wren=%0d rsp=%0d rsp_at=%0d bad=%0d",
               a, en_delay, en_n, wren_n, rsp_n, rsp_k, bad);
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input int latency, input bit silent,
                          input int ncyc, output int acc_wait, output int en_n,
                          output int rsp_n, output int rsp_k, output logic err_seen,
                          output logic [DATA_W-1:0] rdata_seen, output int bad);
      req_valid = 1'b1; req_write = 1'b0; req_addr = a; app_rdy = 1'b1;
      acc_wait = 0;
      while (!req_ready && acc_wait < 20) begin
         @(negedge clk);
         acc_wait++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      en_n = 0; rsp_n = 0; rsp_k = -1; bad = 0; err_seen = 1'b0; rdata_seen = '0;
      for (int k = 0; k < ncyc; k++) begin
         if (app_en) begin
            en_n++;
            if (app_cmd !== 3'd1 || app_addr !== a) bad++;
         end
         if (rsp_valid) begin
            rsp_n++;
            if (rsp_k < 0) begin
               rsp_k = k; err_seen = rsp_err; rdata_seen = rsp_rdata;
            end
         end
         app_rd_data_valid = !silent && (k == 1 + latency);
         app_rd_data = mem.exists(a) ? mem[a] : '0;
         @(negedge clk);
      end
      app_rd_data_valid = 1'b0;
      $display("READ addr=%h lat=%0d silent=%0d en=%0d rsp=%0d rsp_at=%0d err=%0b data[31:0]=%h",
               a, latency, silent, en_n, rsp_n, rsp_k, err_seen, rdata_seen[31:0]);
   endtask

   task automatic test_reset();
      rstn = 1'b0; init_calib_complete = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
      app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, app_en, app_wdf_wren, app_wdf_end, rsp_valid, rsp_err, unexp_rd} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got ready=%b en=%b wren=%b end=%b rsp=%b err=%b unexp=%b want all 0",
                  req_ready, app_en, app_wdf_wren, app_wdf_end, rsp_valid, rsp_err, unexp_rd);
      end
      checks++;
      if (rsp_rdata !== '0 || app_addr !== '0 || app_cmd !== 3'd0) begin
         errors++;
         $display("FAIL reset_data got rdata[31:0]=%h addr=%h cmd=%0d want 0",
                  rsp_rdata[31:0], app_addr, app_cmd);
      end
      rstn = 1'b1;
      $display("RESET released");
   endtask

   task automatic test_calib();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 28'h40;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 1'b0 || app_en !== 1'b0) begin
            errors++;
            $display("FAIL precal_hold cyc=%0d got ready=%b en=%b want 0 0", i, req_ready, app_en);
         end
      end
      init_calib_complete = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL calib_ready got %b want 1", req_ready);
      end
      $display("CALIB complete, ready=%b", req_ready);
   endtask

   task automatic test_write_read();
      int aw, en, wr, rn, rk, bad;
      logic e;
      logic [DATA_W-1:0] rd;
      do_write(28'h40, {64{8'hA5}}, '0, 0, aw, en, wr, rn, rk, bad);
      checks++;
      if (aw !== 0 || en !== 1 || wr !== 1 || rn !== 1 || rk !== 1 || bad !== 0) begin
         errors++;
         $display("FAIL wr_basic got wait=%0d en=%0d wren=%0d rsp=%0d at=%0d bad=%0d want 0 1 1 1 1 0",
                  aw, en, wr, rn, rk, bad);
      end
      do_read(28'h40, 2, 1'b0, 8, aw, en, rn, rk, e, rd, bad);
      checks++;
      if (en !== 1 || rn !== 1 || rk !== 4 || e !== 1'b0 || bad !== 0) begin
         errors++;
         $display("FAIL rd_basic got en=%0d rsp=%0d at=%0d err=%b bad=%0d want 1 1 4 0 0",
                  en, rn, rk, e, bad);
      end
      checks++;
      if (rd !== {64{8'hA5}}) begin
         errors++;
         $display("FAIL rd_data got %h want all A5", rd[63:0]);
      end
   endtask

   task automatic test_write_stall();
      int aw, en, wr, rn, rk, bad;
      do_write(28'h80, {64{8'h3C}}, '0, 5, aw, en, wr, rn, rk, bad);
      checks++;
      if (en !== 6 || wr !== 1 || rn !== 1 || rk !== 6 || bad !== 0) begin
         errors++;
         $display("FAIL wr_stall got en=%0d wren=%0d rsp=%0d at=%0d bad=%0d want 6 1 1 6 0",
                  en, wr, rn, rk, bad);
      end
   endtask

   task automatic test_mask();
      int aw, en, wr, rn, rk, bad;
      logic e;
      logic [DATA_W-1:0] rd, expv;
      do_write(28'h40, '0, 64'hFFFF_FFFF_FFFF_FFFE, 0, aw, en, wr, rn, rk, bad);
      checks++;
      if (rn !== 1 || bad !== 0) begin
         errors++;
         $display("FAIL mask_wr got rsp=%0d bad=%0d want 1 0", rn, bad);
      end
      do_read(28'h40, 0, 1'b0, 6, aw, en, rn, rk, e, rd, bad);
      expv = {64{8'hA5}};
      expv[7:0] = 8'h00;
      checks++;
      if (rd !== expv || rn !== 1 || rk !== 2 || e !== 1'b0) begin
         errors++;
         $display("FAIL mask_rd got data[31:0]=%h rsp=%0d at=%0d err=%b want a5a5a500 1 2 0",
                  rd[31:0], rn, rk, e);
      end
   endtask

   task automatic test_timeout();
      int aw, en, rn, rk, bad;
      logic e;
      logic [DATA_W-1:0] rd;
      checks++;
      if (unexp_rd !== 1'b0) begin
         errors++;
         $display("FAIL unexp_pre got %b want 0", unexp_rd);
      end
      // Command accepted at the edge after k=0; error response 16 edges later -> k=17.
      do_read(28'h40, 0, 1'b1, 22, aw, en, rn, rk, e, rd, bad);
      checks++;
      if (en !== 1 || rn !== 1 || rk !== 17 || e !== 1'b1 || bad !== 0) begin
         errors++;
         $display("FAIL rd_timeout got en=%0d rsp=%0d at=%0d err=%b bad=%0d want 1 1 17 1 0",
                  en, rn, rk, e, bad);
      end
      checks++;
      if (unexp_rd !== 1'b0) begin
         errors++;
         $display("FAIL unexp_before_late got %b want 0", unexp_rd);
      end
      app_rd_data = {64{8'h5A}};
      app_rd_data_valid = 1'b1;
      @(negedge clk);
      app_rd_data_valid = 1'b0;
      checks++;
      if (unexp_rd !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL late_beat got unexp=%b rsp=%b want 1 0", unexp_rd, rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (unexp_rd !== 1'b1) begin
         errors++;
         $display("FAIL unexp_sticky got %b want 1", unexp_rd);
      end
      $display("LATE beat after timeout, unexp_rd=%b", unexp_rd);
   endtask

   task automatic test_reset_mid_read();
      int n_rsp;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 28'h40; app_rdy = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (app_en !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_wait_state got en=%b rsp=%b want 0 0", app_en, rsp_valid);
      end
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if ({req_ready, app_en, app_wdf_wren, rsp_valid, rsp_err, unexp_rd} !== 6'b0 ||
          rsp_rdata !== '0) begin
         errors++;
         $display("FAIL midrst_out got ready=%b en=%b wren=%b rsp=%b err=%b unexp=%b rdata[31:0]=%h want 0",
                  req_ready, app_en, app_wdf_wren, rsp_valid, rsp_err, unexp_rd, rsp_rdata[31:0]);
      end
      init_calib_complete = 1'b0;
      rstn = 1'b1;
      n_rsp = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid || req_ready) n_rsp++;
      end
      checks++;
      if (n_rsp !== 0) begin
         errors++;
         $display("FAIL midrst_quiet got %0d cycles with rsp_valid/req_ready want 0", n_rsp);
      end
      init_calib_complete = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_recal got ready=%b want 1", req_ready);
      end
      $display("RESET mid-read, recalibrated ready=%b", req_ready);
   endtask

   task automatic test_back_to_back();
      int aw, en, rn, rk, bad;
      logic e;
      logic [DATA_W-1:0] rd;
      do_read(28'h80, 1, 1'b0, 6, aw, en, rn, rk, e, rd, bad);
      checks++;
      if (aw !== 0 || rn !== 1 || rk !== 3 || e !== 1'b0 || rd !== {64{8'h3C}}) begin
         errors++;
         $display("FAIL rd_after_rst got wait=%0d rsp=%0d at=%0d err=%b data[31:0]=%h want 0 1 3 0 3c3c3c3c",
                  aw, rn, rk, e, rd[31:0]);
      end
   endtask

   initial begin
      test_reset();
      test_calib();
      test_write_read();
      test_write_stall();
      test_mask();
      test_timeout();
      test_reset_mid_read();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
